// File: rtl/fp16_rmul_2stage_if.sv
// Operand/result bundle for the two-stage reduced-precision binary16 multiplier.
//   s0_arg_0/1 : operands A and B (binary16)
//   s0_ret_0   : product sign
//   s0_ret_1/2 : raw exponent fields of A and B
//   s0_ret_3   : truncated mantissa product P[21:10]
//   s1_arg_0..3: sign, exponent A, exponent B, mantissa product fed to stage 1
//   s1_ret_0   : packed binary16 product
// The master modport drives the arguments and observes the results; the
// slave modport (the multiplier) does the opposite.
interface fp16_rmul_2stage_if;
    logic [15:0] s0_arg_0;
    logic [15:0] s0_arg_1;
    logic        s0_ret_0;
    logic [4:0]  s0_ret_1;
    logic [4:0]  s0_ret_2;
    logic [11:0] s0_ret_3;
    logic        s1_arg_0;
    logic [4:0]  s1_arg_1;
    logic [4:0]  s1_arg_2;
    logic [11:0] s1_arg_3;
    logic [15:0] s1_ret_0;

    modport master (
        output s0_arg_0, s0_arg_1,
        output s1_arg_0, s1_arg_1, s1_arg_2, s1_arg_3,
        input  s0_ret_0, s0_ret_1, s0_ret_2, s0_ret_3,
        input  s1_ret_0
    );

    modport slave (
        input  s0_arg_0, s0_arg_1,
        input  s1_arg_0, s1_arg_1, s1_arg_2, s1_arg_3,
        output s0_ret_0, s0_ret_1, s0_ret_2, s0_ret_3,
        output s1_ret_0
    );
endinterface

// File: rtl/fp16_rmul_2stage.sv
// Reduced-precision binary16 multiplier split into two combinational stages
// so a scheduler can place them in consecutive states.
//   clk   : present for interface uniformity; unused
//   rst   : active-low reset, present for uniformity; there is no state
//   bus   : slave side of fp16_rmul_2stage_if (stage 0 and stage 1 signals)
// Stage 0: sign, raw exponents and the truncated 11x11 mantissa product.
// Stage 1: exponent sum, one-bit normalization, special cases, packing.
// Denormals flush to zero, results truncate, overflow saturates to infinity,
// NaN is not propagated.
module fp16_rmul_2stage (
    input  logic                       clk,
    input  logic                       rst,
    fp16_rmul_2stage_if.slave          bus
);
    // Clock and reset are deliberately not used by any logic.
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst;

    // ---------------- Stage 0 ----------------
    logic [10:0] mant_a;
    logic [10:0] mant_b;
    logic [21:0] product;
    logic [9:0]  unused_product_low;

    // Hidden bit is always forced to 1; zero/denormal operands are caught
    // later from the exponent field.
    assign mant_a  = {1'b1, bus.s0_arg_0[9:0]};
    assign mant_b  = {1'b1, bus.s0_arg_1[9:0]};
    assign product = {11'd0, mant_a} * {11'd0, mant_b};

    assign bus.s0_ret_0 = bus.s0_arg_0[15] ^ bus.s0_arg_1[15];
    assign bus.s0_ret_1 = bus.s0_arg_0[14:10];
    assign bus.s0_ret_2 = bus.s0_arg_1[14:10];
    assign bus.s0_ret_3 = product[21:10];
    assign unused_product_low = product[9:0];

    // ---------------- Stage 1 ----------------
    logic              norm_shift;
    logic [9:0]        frac;
    logic [6:0]        exp_sum;
    logic signed [6:0] exp_val;
    logic              zero_in;
    logic              special_in;

    // Product of two values in [1,2) lies in [1,4); m[11] means >= 2.
    assign norm_shift = bus.s1_arg_3[11];
    assign frac       = norm_shift ? bus.s1_arg_3[10:1] : bus.s1_arg_3[9:0];

    // 7-bit signed range (-15..48) keeps underflow and overflow visible.
    assign exp_sum = {2'b00, bus.s1_arg_1} + {2'b00, bus.s1_arg_2}
                   + {6'd0, norm_shift};
    assign exp_val = $signed(exp_sum) - 7'sd15;

    assign zero_in    = (bus.s1_arg_1 == 5'd0) || (bus.s1_arg_2 == 5'd0);
    assign special_in = (bus.s1_arg_1 == 5'd31) || (bus.s1_arg_2 == 5'd31);

    always_comb begin
        bus.s1_ret_0 = 16'h0000;
        if (zero_in) begin
            bus.s1_ret_0 = 16'h0000;
        end else if (exp_val <= 7'sd0) begin
            bus.s1_ret_0 = 16'h0000;
        end else if ((exp_val >= 7'sd31) || special_in) begin
            bus.s1_ret_0 = {bus.s1_arg_0, 5'd31, 10'd0};
        end else begin
            bus.s1_ret_0 = {bus.s1_arg_0, exp_val[4:0], frac};
        end
    end
endmodule

// File: tb/tb_fp16_rmul_2stage.sv
module tb_fp16_rmul_2stage;
    logic clk;
    logic rst;
    logic clk_run;
    int   checks;
    int   failures;

    fp16_rmul_2stage_if bus ();

    fp16_rmul_2stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp_v);
        end
        $display("%s obs=%04h exp=%04h", tag, obs, exp_v);
    endtask

    task automatic check_s0(input string tag, input logic sgn, input logic [4:0] ea,
                            input logic [4:0] eb, input logic [11:0] m);
        logic [22:0] obs;
        logic [22:0] exp_v;
        obs   = {bus.s0_ret_0, bus.s0_ret_1, bus.s0_ret_2, bus.s0_ret_3};
        exp_v = {sgn, ea, eb, m};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp_v);
        end
        $display("%s obs=%06h exp=%06h", tag, obs, exp_v);
    endtask

    // Full multiply: apply operands, forward stage-0 results into stage 1.
    task automatic mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_v);
        bus.s0_arg_0 = a;
        bus.s0_arg_1 = b;
        #1;
        bus.s1_arg_0 = bus.s0_ret_0;
        bus.s1_arg_1 = bus.s0_ret_1;
        bus.s1_arg_2 = bus.s0_ret_2;
        bus.s1_arg_3 = bus.s0_ret_3;
        #1;
        check16(tag, bus.s1_ret_0, exp_v);
    endtask

    // Stage 1 alone with arbitrary inputs.
    task automatic st1(input string tag, input logic s, input logic [4:0] ea,
                       input logic [4:0] eb, input logic [11:0] m, input logic [15:0] exp_v);
        bus.s1_arg_0 = s;
        bus.s1_arg_1 = ea;
        bus.s1_arg_2 = eb;
        bus.s1_arg_3 = m;
        #1;
        check16(tag, bus.s1_ret_0, exp_v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk_run  = 1'b0;
        rst      = 1'b0;
        bus.s0_arg_0 = 16'h0000;
        bus.s0_arg_1 = 16'h0000;
        bus.s1_arg_0 = 1'b0;
        bus.s1_arg_1 = 5'd0;
        bus.s1_arg_2 = 5'd0;
        bus.s1_arg_3 = 12'd0;
        #2;
        rst = 1'b1;
        #1;

        mul("zero_x_zero", 16'h0000, 16'h0000, 16'h0000);
        mul("one_x_one",   16'h3C00, 16'h3C00, 16'h3C00);
        check_s0("s0_one_x_one", 1'b0, 5'd15, 5'd15, 12'h400);
        mul("1p5_x_1p5",   16'h3E00, 16'h3E00, 16'h4080);
        check_s0("s0_1p5_x_1p5", 1'b0, 5'd15, 5'd15, 12'h900);
        mul("1p25_x_1p25", 16'h3D00, 16'h3D00, 16'h3E40);
        check_s0("s0_1p25_x_1p25", 1'b0, 5'd15, 5'd15, 12'h640);
        mul("0p75_x_0p75", 16'h3A00, 16'h3A00, 16'h3880);
        mul("underflow",   16'h0400, 16'h3800, 16'h0000);
        mul("overflow",    16'h6000, 16'h6000, 16'h7C00);
        mul("neg1_x_1p5",  16'hBC00, 16'h3E00, 16'hBE00);
        check_s0("s0_neg1_x_1p5", 1'b1, 5'd15, 5'd15, 12'h600);
        mul("inf_x_zero",  16'h7C00, 16'h0000, 16'h0000);
        mul("inf_x_neg1",  16'h7C00, 16'hBC00, 16'hFC00);

        // Stage-1 boundaries driven directly.
        st1("s1_zero_prio",  1'b1, 5'd31, 5'd0,  12'h000, 16'h0000);
        st1("s1_exp_neg",    1'b1, 5'd1,  5'd1,  12'h000, 16'h0000);
        st1("s1_exp0_norm",  1'b0, 5'd7,  5'd7,  12'h800, 16'h0000);
        st1("s1_exp1",       1'b0, 5'd8,  5'd8,  12'h000, 16'h0400);
        st1("s1_exp30",      1'b0, 5'd22, 5'd23, 12'h000, 16'h7800);
        st1("s1_exp31",      1'b0, 5'd23, 5'd23, 12'h000, 16'h7C00);
        st1("s1_exp32_norm", 1'b1, 5'd30, 5'd16, 12'h800, 16'hFC00);
        st1("s1_max_frac",   1'b1, 5'd20, 5'd10, 12'h3FF, 16'hBFFF);
        st1("s1_nan_in",     1'b0, 5'd31, 5'd1,  12'h000, 16'h7C00);

        // Reset/clock independence: same operands, rst low/high, clk static/toggling.
        rst = 1'b0;
        mul("rst_lo_static", 16'h3E00, 16'h3E00, 16'h4080);
        rst = 1'b1;
        mul("rst_hi_static", 16'h3E00, 16'h3E00, 16'h4080);
        clk_run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mul("rst_lo_clk", 16'hBC00, 16'h3E00, 16'hBE00);
        @(posedge clk);
        #1;
        check16("rst_lo_clk_hold", bus.s1_ret_0, 16'hBE00);
        rst = 1'b1;
        @(negedge clk);
        mul("rst_hi_clk", 16'hBC00, 16'h3E00, 16'hBE00);
        clk_run = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp16_rmul_2stage.md
Name: fp16_rmul_2stage

Overview:
- Reduced-precision IEEE-754 binary16 multiplier, split into two purely combinational stages so a scheduler can place them in consecutive states.
- Stage 0 unpacks the operands and forms the sign and the mantissa product.
- Stage 1 adds the exponents, normalizes, and packs the result.
- Denormals are flushed to zero; results are truncated (no rounding); overflow saturates to infinity.

Parameters:
- none (format fixed at binary16: 1 sign, 5 exponent, 10 fraction, bias 15)

Ports:
- clk  in  1  clock; present for interface uniformity, no logic uses it
- rst  in  1  asynchronous active-low reset; present for uniformity, no state to reset
- s0_arg_0  in  16  operand A, binary16
- s0_arg_1  in  16  operand B, binary16
- s0_ret_0  out  1  product sign = A[15] xor B[15]
- s0_ret_1  out  5  exponent field of A (A[14:10])
- s0_ret_2  out  5  exponent field of B (B[14:10])
- s0_ret_3  out  12  truncated mantissa product, bits [21:10] of P
- s1_arg_0  in  1  sign from stage 0
- s1_arg_1  in  5  exponent A from stage 0
- s1_arg_2  in  5  exponent B from stage 0
- s1_arg_3  in  12  mantissa product from stage 0
- s1_ret_0  out  16  packed binary16 product

Behaviour:
- Latency and state:
  - Both stages are fully combinational with zero latency; no registers.
  - Outputs settle within the same simulation time step as the inputs change.
  - clk and rst have no effect on outputs; asserting rst (low) at any time changes nothing.
  - No reset values exist; outputs are always a pure function of the current inputs.
- Stage 0:
  - P = {1,A[9:0]} * {1,B[9:0]}, an unsigned 11x11 -> 22-bit product.
  - s0_ret_3 = P[21:10].
  - The sign and both exponents pass straight through; stage 0 applies no special-case handling.
- Stage 1 inputs: s = s1_arg_0, ea = s1_arg_1, eb = s1_arg_2, m = s1_arg_3.
- Stage 1 normalization:
  - If m[11]=1: frac = m[10:1], exp = ea + eb - 15 + 1.
  - Else: frac = m[9:0], exp = ea + eb - 15.
  - Compute exp with at least 7-bit signed width so that negatives and values ≥31 are detectable.
- Stage 1 result selection, in priority order:
  1. ea==0 or eb==0 (zero/denormal input) -> 16'h0000 (+0, sign dropped).
  2. exp ≤ 0 (underflow) -> 16'h0000.
  3. exp ≥ 31, or ea==31, or eb==31 (overflow, Inf or NaN input) -> {s, 5'd31, 10'd0}, a signed infinity. NaN is not propagated.
  4. Otherwise -> {s, exp[4:0], frac}.
- Rounding: truncation toward zero; the discarded low product bits P[9:0] (and P[10] when normalizing) are ignored.
- Composition: connecting s0_ret_k to s1_arg_k yields the full multiply. Any stage-1 input combination must produce a defined result per the rules above.

Test Plan:
- A=0x0000, B=0x0000 -> s1_ret_0 = 0x0000.
- Mantissa chain:
  - A=B=0x3C00 (1.0) -> sign 0, exp 15, frac 0 (0x3C00).
  - A=B=0x3E00 (1.5) -> sign 0, exp 16, frac 128 (0x4080); checks the m[11] normalization path.
  - A=B=0x3D00 (1.25) -> sign 0, exp 15, frac 576 (0x3E40).
  - A=B=0x3A00 (0.75) -> sign 0, exp 14, frac 128 (0x3880).
- Underflow and overflow:
  - A=0x0400 (2^-14), B=0x3800 (0.5) -> 0x0000 (flush).
  - A=B=0x6000 (2^9) -> 0x7C00 (+Inf).
- Sign and special operands:
  - A=0xBC00 (-1.0), B=0x3E00 -> 0xBE00 (sign 1, exp 15, frac 512).
  - A=0x7C00 (Inf), B=0x0000 -> 0x0000 (zero priority).
  - A=0x7C00, B=0xBC00 -> 0xFC00.
- Reset and clock independence: hold rst low, then high, with clk static and with clk toggling; outputs must be identical for identical operands in all cases.
